// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide unit with HI/LO registers for the
// E stage of the p5/p6 MIPS core. The 64-bit result is computed when the
// operation issues and parked in shadow registers. HI/LO are only updated once
// the configured latency has elapsed, so the unit behaves like a real
// iterative multiplier/divider as seen by the hazard logic.
// Optional feature macro: MDU_CANCEL_EN adds a 'cancel' input that flushes an
// in-flight operation (exception/interrupt) without committing it.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The counter holds the number of edges left before the commit edge.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_sh_hi;
  logic [31:0]      r_sh_lo;
  logic             r_dz;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_cancel;
  logic             w_start_md;
  logic [63:0]      w_mul_s;
  logic [63:0]      w_mul_u;
  logic [31:0]      w_rs_mag;
  logic [31:0]      w_rt_mag;
  logic [31:0]      w_qmag;
  logic [31:0]      w_rmag;
  logic [31:0]      w_divu_q;
  logic [31:0]      w_divu_r;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;

`ifdef MDU_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  // md_op 000..011 are the multi-cycle ops; MTHI/MTLO never stall.
  assign w_start_md = start & ~md_op[2];

  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign stall = d_md_use & (busy | w_start_md);
  assign hi    = r_hi;
  assign lo    = r_lo;

  // Products: sign-extend for MULT, zero-extend for MULTU.
  assign w_mul_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign w_mul_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide works on magnitudes so that 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without any overflow special case.
  assign w_rs_mag = rs_val[31] ? (32'd0 - rs_val) : rs_val;
  assign w_rt_mag = rt_val[31] ? (32'd0 - rt_val) : rt_val;
  assign w_qmag   = (w_rt_mag == 32'd0) ? 32'd0 : (w_rs_mag / w_rt_mag);
  assign w_rmag   = (w_rt_mag == 32'd0) ? 32'd0 : (w_rs_mag % w_rt_mag);
  assign w_divu_q = (rt_val == 32'd0) ? 32'd0 : (rs_val / rt_val);
  assign w_divu_r = (rt_val == 32'd0) ? 32'd0 : (rs_val % rt_val);

  // Select the 64-bit result for the issuing op.
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (md_op[1:0])
      2'b00: begin
        w_res_hi = w_mul_s[63:32];
        w_res_lo = w_mul_s[31:0];
      end
      2'b01: begin
        w_res_hi = w_mul_u[63:32];
        w_res_lo = w_mul_u[31:0];
      end
      2'b10: begin
        w_res_lo = (rs_val[31] ^ rt_val[31]) ? (32'd0 - w_qmag) : w_qmag;
        w_res_hi = rs_val[31] ? (32'd0 - w_rmag) : w_rmag;
      end
      default: begin
        w_res_lo = w_divu_q;
        w_res_hi = w_divu_r;
      end
    endcase
  end

  // Control FSM, latency counter, shadow result and the HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh_hi <= 32'd0;
      r_sh_lo <= 32'd0;
      r_dz    <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_cancel) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            // Divide by zero runs the full latency but leaves HI/LO alone.
            if (!r_dz) begin
              r_hi <= r_sh_hi;
              r_lo <= r_sh_lo;
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          // IDLE and DONE accept new work identically.
          r_state <= S_IDLE;
          if (start) begin
            case (md_op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_state <= S_RUN;
                r_cnt   <= md_op[1] ? DIV_LOAD : MULT_LOAD;
                r_sh_hi <= w_res_hi;
                r_sh_lo <= w_res_lo;
                r_dz    <= md_op[1] & (rt_val == 32'd0);
              end
              3'b100:  r_hi <= rs_val;
              3'b101:  r_lo <= rs_val;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Testbench for md_unit_ctrl: directed scenarios followed by random issue
// traffic. Expected results are queued at issue and checked by a separate
// monitor whenever the DUT raises done.
module tb_md_unit_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        d_md_use = 1'b0;
  logic        cancel = 1'b0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .d_md_use(d_md_use),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model: architectural HI/LO plus one pending operation.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          p_valid = 1'b0;
  int          p_commit = 0;
  logic [31:0] p_hi = 32'd0;
  logic [31:0] p_lo = 32'd0;
  bit          p_dz = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic bit busy_now();
    return p_valid && (cyc < p_commit);
  endfunction

  // MIPS semantics computed with wide integer arithmetic.
  function automatic void ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    rh = m_hi;
    rl = m_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = ua * ub;      rh = p[63:32]; rl = p[31:0]; end
      3'd2: if (b != 32'd0) begin
        q = sa / sb; r = sa % sb;
        p = 64'(q); rl = p[31:0];
        p = 64'(r); rh = p[31:0];
      end
      default: if (b != 32'd0) begin rl = a / b; rh = a % b; end
    endcase
  endfunction

  // One clock of stimulus: check registered outputs, drive, check stall,
  // then advance the model across the rising edge.
  task automatic tick(input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit use_in, input bit can);
    bit          was_busy;
    logic [31:0] rh, rl;
    chk("busy", {63'd0, busy}, {63'd0, busy_now()});
    chk("done", {63'd0, done}, {63'd0, p_valid && (cyc == p_commit)});
    chk("hi", {32'd0, hi}, {32'd0, m_hi});
    chk("lo", {32'd0, lo}, {32'd0, m_lo});
    start = st; md_op = op; rs_val = a; rt_val = b; d_md_use = use_in; cancel = can;
    #1;
    chk("stall", {63'd0, stall}, {63'd0, use_in && (busy_now() || (st && op < 3'd4))});
    @(posedge clk);
    was_busy = busy_now();
    cyc++;
    if (can && was_busy) begin
      p_valid = 1'b0;
      void'(sb_q.pop_back());
      $display("cycle %0d: cancel", cyc);
    end else if (p_valid && cyc == p_commit && !p_dz) begin
      m_hi = p_hi;
      m_lo = p_lo;
    end
    if (st && was_busy) begin
      $display("cycle %0d: start op=%0d ignored (busy)", cyc, op);
    end else if (st) begin
      case (op)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          ref_result(op, a, b, rh, rl);
          p_valid  = 1'b1;
          p_commit = cyc + ((op >= 3'd2) ? DIV_N : MULT_N);
          p_dz     = (op >= 3'd2) && (b == 32'd0);
          p_hi     = rh;
          p_lo     = rl;
          sb_q.push_back('{hi: rh, lo: rl, cyc: p_commit});
          $display("cycle %0d: issue op=%0d rs=%h rt=%h -> hi=%h lo=%h", cyc, op, a, b, rh, rl);
        end
        3'd4: begin m_hi = a; $display("cycle %0d: MTHI %h", cyc, a); end
        3'd5: begin m_lo = a; $display("cycle %0d: MTLO %h", cyc, a); end
        default: $display("cycle %0d: no-op md_op=%0d", cyc, op);
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit use_in);
    for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 32'd0, 32'd0, use_in, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear at once.
  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0; p_valid = 1'b0;
    sb_q.delete();
    $display("cycle %0d: reset asserted", cyc);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: compare the committed result whenever done pulses.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d: got done=1, expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("res_hi", {32'd0, hi}, {32'd0, e.hi});
        chk("res_lo", {32'd0, lo}, {32'd0, e.lo});
        $display("cycle %0d: done hi=%h lo=%h", cyc, hi, lo);
      end
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Idle after reset.
    idle(2, 1'b1);
    // MULT -2 * 3 with stall polling.
    tick(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    idle(7, 1'b1);
    // DIVU 100 / 7 with the D stage waiting throughout.
    tick(1'b1, 3'd3, 32'd100, 32'd7, 1'b1, 1'b0);
    idle(11, 1'b1);
    // DIV -7 / 2, then divide by zero.
    tick(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(11, 1'b0);
    tick(1'b1, 3'd2, 32'd5, 32'd0, 1'b0, 1'b0);
    idle(11, 1'b0);
    // Overflowing signed divide.
    tick(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(11, 1'b0);
    // MTHI/MTLO while idle, then a start during RUN that must be ignored.
    tick(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    tick(1'b1, 3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    tick(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(1'b1, 3'd0, 32'd9, 32'd9, 1'b1, 1'b0);
    tick(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    idle(5, 1'b0);
    // Undefined opcode.
    tick(1'b1, 3'd7, 32'h5555_5555, 32'd1, 1'b1, 1'b0);
    idle(1, 1'b0);
    // Reset in the middle of a RUN.
    tick(1'b1, 3'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
    idle(3, 1'b0);
    reset_pulse();
    idle(2, 1'b0);
`ifdef MDU_CANCEL_EN
    // Cancel two cycles after issue.
    tick(1'b1, 3'd4, 32'h0BAD_0BAD, 32'd0, 1'b0, 1'b0);
    tick(1'b1, 3'd2, 32'd1000, 32'd3, 1'b0, 1'b0);
    idle(1, 1'b0);
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(12, 1'b0);
`endif

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      bit can;
      can = 1'b0;
`ifdef MDU_CANCEL_EN
      can = ($urandom_range(0, 24) == 0);
`endif
      tick(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
           1'($urandom_range(0, 1)), can);
    end
    idle(12, 1'b0);
    chk("queue_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
